// File: rtl/apb_fabric_pkg.sv
// Shared types and constants for the APB fan-out fabric with wait-state watchdog.
package apb_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } fab_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          ERR_CNT_W        = 8;

    // Index width for a one-hot select of n slaves; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_fabric_timeout_if.sv
// Bus bundle around the fabric: master-side APB plus the fanned-out slave side.
// The master modport is the environment (APB master and peripherals); the slave modport is the fabric.
interface apb_fabric_timeout_if #(
    parameter int N_SLAVES = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [N_SLAVES-1:0]        m_psel;
    logic                       m_penable;
    logic                       m_pwrite;
    logic [ADDR_W-1:0]          m_paddr;
    logic [DATA_W-1:0]          m_pwdata;
    logic                       m_pready;
    logic [DATA_W-1:0]          m_prdata;
    logic                       m_pslverr;
    logic [N_SLAVES-1:0]        s_psel;
    logic                       s_penable;
    logic                       s_pwrite;
    logic [ADDR_W-1:0]          s_paddr;
    logic [DATA_W-1:0]          s_pwdata;
    logic [N_SLAVES-1:0]        s_pready;
    logic [N_SLAVES*DATA_W-1:0] s_prdata;

    modport master (
        output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, s_pready, s_prdata,
        input  m_pready, m_prdata, m_pslverr, s_psel, s_penable, s_pwrite, s_paddr, s_pwdata
    );

    modport slave (
        input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, s_pready, s_prdata,
        output m_pready, m_prdata, m_pslverr, s_psel, s_penable, s_pwrite, s_paddr, s_pwdata
    );
endinterface

// File: rtl/apb_sel_encoder.sv
// One-hot select to binary index, with flags for an empty or multi-hot select.
module apb_sel_encoder
    import apb_fabric_pkg::*;
#(
    parameter int N_SLAVES = 8,
    parameter int IDX_W    = idx_w(N_SLAVES)
) (
    input  logic [N_SLAVES-1:0] sel,
    output logic [IDX_W-1:0]    idx,
    output logic                multi,
    output logic                zero
);

    logic [4:0] ones_s;

    // OR-reduce the indices of set bits; only meaningful when exactly one is set.
    always_comb begin
        idx    = '0;
        ones_s = 5'd0;
        for (int i = 0; i < N_SLAVES; i++) begin
            idx    = sel[i] ? (idx | IDX_W'(i)) : idx;
            ones_s = ones_s + {4'd0, sel[i]};
        end
        multi = (ones_s > 5'd1);
        zero  = (ones_s == 5'd0);
    end

endmodule

// File: rtl/apb_fabric_timeout.sv
// Registered APB fan-out to N_SLAVES ports with a wait-state watchdog, PSLVERR
// generation on timeout or multi-hot select, and sticky/saturating error status.
module apb_fabric_timeout
    import apb_fabric_pkg::*;
#(
    parameter int                N_SLAVES = 8,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_fabric_timeout_if.slave  bus,
    input  logic                 err_clr,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int                   IDX_W    = idx_w(N_SLAVES);
    localparam logic [15:0]          CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

    fab_state_e            state_r, state_nxt_s;
    logic [IDX_W-1:0]      enc_idx_s, idx_r;
    logic                  enc_multi_s, enc_zero_s;
    logic                  rdy_s, latch_s, err_rsp_s;
    logic [DATA_W-1:0]     rdata_s;
    logic [N_SLAVES-1:0]   s_psel_r, s_psel_nxt_s;
    logic                  s_penable_r, s_penable_nxt_s, s_pwrite_r;
    logic [ADDR_W-1:0]     s_paddr_r;
    logic [DATA_W-1:0]     s_pwdata_r;
    logic                  m_pready_r, m_pready_nxt_s;
    logic                  m_pslverr_r, m_pslverr_nxt_s;
    logic [DATA_W-1:0]     m_prdata_r, m_prdata_nxt_s;
    logic [15:0]           cnt_r, cnt_nxt_s;
    logic                  err_sticky_r;
    logic [ERR_CNT_W-1:0]  err_count_r;

    apb_sel_encoder #(.N_SLAVES(N_SLAVES), .IDX_W(IDX_W)) u_enc (
        .sel   (bus.m_psel),
        .idx   (enc_idx_s),
        .multi (enc_multi_s),
        .zero  (enc_zero_s)
    );

    // Pick the ready and read data of the latched slave.
    always_comb begin
        rdy_s   = 1'b0;
        rdata_s = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            rdy_s   = (idx_r == IDX_W'(k)) ? bus.s_pready[k] : rdy_s;
            rdata_s = (idx_r == IDX_W'(k)) ? bus.s_prdata[k*DATA_W +: DATA_W] : rdata_s;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt_s     = state_r;
        s_psel_nxt_s    = s_psel_r;
        s_penable_nxt_s = s_penable_r;
        m_pready_nxt_s  = 1'b0;
        m_pslverr_nxt_s = 1'b0;
        m_prdata_nxt_s  = '0;
        cnt_nxt_s       = cnt_r;
        latch_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 16'd0;
                if (!enc_zero_s && !bus.m_penable) begin
                    latch_s = 1'b1;
                    if (enc_multi_s) begin
                        state_nxt_s     = ST_RESP;
                        m_pready_nxt_s  = 1'b1;
                        m_pslverr_nxt_s = 1'b1;
                        m_prdata_nxt_s  = ERR_DATA;
                    end else begin
                        state_nxt_s  = ST_SETUP;
                        s_psel_nxt_s = bus.m_psel;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (enc_zero_s) begin
                    state_nxt_s  = ST_IDLE;
                    s_psel_nxt_s = '0;
                end else begin
                    state_nxt_s     = ST_ACCESS;
                    s_penable_nxt_s = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Master abort outranks a slave response landing in the same cycle.
                if (enc_zero_s) begin
                    state_nxt_s     = ST_IDLE;
                    s_psel_nxt_s    = '0;
                    s_penable_nxt_s = 1'b0;
                    cnt_nxt_s       = 16'd0;
                end else if (rdy_s) begin
                    state_nxt_s     = ST_RESP;
                    s_psel_nxt_s    = '0;
                    s_penable_nxt_s = 1'b0;
                    cnt_nxt_s       = 16'd0;
                    m_pready_nxt_s  = 1'b1;
                    m_prdata_nxt_s  = s_pwrite_r ? '0 : rdata_s;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s     = ST_RESP;
                    s_psel_nxt_s    = '0;
                    s_penable_nxt_s = 1'b0;
                    cnt_nxt_s       = 16'd0;
                    m_pready_nxt_s  = 1'b1;
                    m_pslverr_nxt_s = 1'b1;
                    m_prdata_nxt_s  = ERR_DATA;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 16'd0;
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                s_psel_nxt_s    = '0;
                s_penable_nxt_s = 1'b0;
                cnt_nxt_s       = 16'd0;
            end
        endcase
    end

    // State, strobes, response and watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            s_psel_r    <= '0;
            s_penable_r <= 1'b0;
            m_pready_r  <= 1'b0;
            m_pslverr_r <= 1'b0;
            m_prdata_r  <= '0;
            cnt_r       <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            s_psel_r    <= s_psel_nxt_s;
            s_penable_r <= s_penable_nxt_s;
            m_pready_r  <= m_pready_nxt_s;
            m_pslverr_r <= m_pslverr_nxt_s;
            m_prdata_r  <= m_prdata_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    // Transfer attributes captured at master SETUP and held for the slave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_pwrite_r <= 1'b0;
            s_paddr_r  <= '0;
            s_pwdata_r <= '0;
            idx_r      <= '0;
        end else if (latch_s) begin
            s_pwrite_r <= bus.m_pwrite;
            s_paddr_r  <= bus.m_paddr;
            s_pwdata_r <= bus.m_pwdata;
            idx_r      <= enc_idx_s;
        end
    end

    assign err_rsp_s = (state_r == ST_RESP) && m_pslverr_r;

    // Error status is booked on the error response cycle; a clear in that cycle leaves count 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_r <= 1'b0;
            err_count_r  <= '0;
        end else if (err_clr) begin
            err_sticky_r <= 1'b0;
            err_count_r  <= err_rsp_s ? ERR_CNT_W'(1) : '0;
        end else if (err_rsp_s) begin
            err_sticky_r <= 1'b1;
            err_count_r  <= (err_count_r == CNT_MAX) ? err_count_r : err_count_r + ERR_CNT_W'(1);
        end
    end

    assign bus.s_psel    = s_psel_r;
    assign bus.s_penable = s_penable_r;
    assign bus.s_pwrite  = s_pwrite_r;
    assign bus.s_paddr   = s_paddr_r;
    assign bus.s_pwdata  = s_pwdata_r;
    assign bus.m_pready  = m_pready_r;
    assign bus.m_prdata  = m_prdata_r;
    assign bus.m_pslverr = m_pslverr_r;
    assign err_sticky    = err_sticky_r;
    assign err_count     = err_count_r;

endmodule

// File: tb/tb_apb_fabric_timeout.sv
// Self-checking bench for apb_fabric_timeout: directed table, corner sequences and
// randomized transfers scored against a transfer-level outcome model.
module tb_apb_fabric_timeout;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct {
        logic [7:0]  psel;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          lat;
        logic [31:0] edata;
        bit          eerr;
    } vec_t;

    logic        clk, rst, err_clr, err_sticky;
    logic [7:0]  err_count;
    int          n_vec, n_bad;
    int          exp_cnt;
    bit          exp_sticky;
    int          wait_cfg [8];
    logic [31:0] slave_data [8];
    int          acc_cnt;
    vec_t        tbl [9];
    vec_t        v;

    apb_fabric_timeout_if #(.N_SLAVES(8), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_fabric_timeout #(.N_SLAVES(8), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model: slave k raises ready once it has seen wait_cfg[k] ACCESS cycles.
    always_ff @(posedge clk) acc_cnt <= bus.s_penable ? acc_cnt + 1 : 0;

    always_comb begin
        bus.s_pready = '0;
        bus.s_prdata = '0;
        for (int k = 0; k < 8; k++) begin
            bus.s_pready[k]         = bus.s_psel[k] & bus.s_penable & (acc_cnt >= wait_cfg[k]);
            bus.s_prdata[k*32 +: 32] = slave_data[k];
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Outcome of one transfer from the rules alone: who errors, after how long, with what data.
    function automatic void model(inout vec_t x);
        if ($countones(x.psel) > 1) begin
            x.lat = 1; x.edata = ERR; x.eerr = 1'b1;
        end else if (x.waits >= TO) begin
            x.lat = 2 + TO; x.edata = ERR; x.eerr = 1'b1;
        end else begin
            x.lat = 3 + x.waits; x.edata = x.wr ? 32'h0 : x.rdata; x.eerr = 1'b0;
        end
    endfunction

    task automatic run_xfer(input vec_t x, input bit clr_at_resp);
        int n;
        bit done, onehot;
        onehot = ($countones(x.psel) == 1);
        for (int k = 0; k < 8; k++) begin
            if (x.psel[k] && onehot) begin
                wait_cfg[k] = x.waits; slave_data[k] = x.rdata;
            end else begin
                wait_cfg[k] = 0; slave_data[k] = ~x.rdata ^ 32'(k * 17);
            end
        end
        bus.m_psel = x.psel; bus.m_penable = 1'b0; bus.m_pwrite = x.wr;
        bus.m_paddr = x.addr; bus.m_pwdata = x.wdata;
        n = 0; done = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk); #1; n++;
            if (n == 1) chk("s_psel_setup", bus.s_psel, onehot ? x.psel : 8'h00);
            if (bus.s_penable)
                chk("s_hold", {bus.s_psel, bus.s_pwrite, bus.s_paddr, bus.s_pwdata},
                    {x.psel, x.wr, x.addr, x.wdata});
            if (bus.m_pready) begin
                done = 1'b1;
                chk("latency", n, x.lat);
                chk("m_prdata", bus.m_prdata, x.edata);
                chk("m_pslverr", bus.m_pslverr, x.eerr);
                bus.m_psel = 8'h00; bus.m_penable = 1'b0; err_clr = clr_at_resp;
            end else begin
                bus.m_penable = 1'b1;
            end
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL xfer_budget actual=no_pready required=pready_within_100");
            bus.m_psel = 8'h00; bus.m_penable = 1'b0;
        end
        @(posedge clk); #1; err_clr = 1'b0;
        if (clr_at_resp) begin
            exp_sticky = 1'b0; exp_cnt = x.eerr ? 1 : 0;
        end else if (x.eerr) begin
            exp_sticky = 1'b1; exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        end
        chk("err_count", err_count, exp_cnt);
        chk("err_sticky", err_sticky, exp_sticky);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.m_pready, bus.m_prdata, bus.m_pslverr, bus.s_psel, bus.s_penable,
                   bus.s_pwrite, err_sticky, err_count}, '0);
        chk({name, "_addr_data"}, {bus.s_paddr, bus.s_pwdata}, '0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; exp_cnt = 0; exp_sticky = 1'b0;
        rst = 1'b1; err_clr = 1'b0;
        bus.m_psel = 8'h00; bus.m_penable = 1'b0; bus.m_pwrite = 1'b0;
        bus.m_paddr = 32'h0; bus.m_pwdata = 32'h0;
        for (int k = 0; k < 8; k++) begin wait_cfg[k] = 0; slave_data[k] = 32'h0; end

        tbl[0] = '{psel:8'h04, wr:1'b0, addr:32'h0000_0100, wdata:32'h0,         rdata:32'h1234_5678, waits:0,   lat:3,  edata:32'h1234_5678, eerr:1'b0};
        tbl[1] = '{psel:8'h01, wr:1'b1, addr:32'h0000_0004, wdata:32'hCAFE_F00D, rdata:32'h5555_AAAA, waits:3,   lat:6,  edata:32'h0,         eerr:1'b0};
        tbl[2] = '{psel:8'h20, wr:1'b0, addr:32'h0000_0520, wdata:32'h0,         rdata:32'h7777_7777, waits:255, lat:18, edata:32'hDEAD_BEEF, eerr:1'b1};
        tbl[3] = '{psel:8'h05, wr:1'b0, addr:32'h0000_0008, wdata:32'h0,         rdata:32'h1111_2222, waits:0,   lat:1,  edata:32'hDEAD_BEEF, eerr:1'b1};
        tbl[4] = '{psel:8'h80, wr:1'b0, addr:32'h0000_0700, wdata:32'h0,         rdata:32'hA5A5_0F0F, waits:15,  lat:18, edata:32'hA5A5_0F0F, eerr:1'b0};
        tbl[5] = '{psel:8'h02, wr:1'b0, addr:32'h0000_0110, wdata:32'h0,         rdata:32'h3333_4444, waits:16,  lat:18, edata:32'hDEAD_BEEF, eerr:1'b1};
        tbl[6] = '{psel:8'h08, wr:1'b1, addr:32'h0000_0330, wdata:32'h0102_0304, rdata:32'h9999_8888, waits:20,  lat:18, edata:32'hDEAD_BEEF, eerr:1'b1};
        tbl[7] = '{psel:8'hFF, wr:1'b1, addr:32'h0000_0FF0, wdata:32'hFFFF_0000, rdata:32'h0,         waits:0,   lat:1,  edata:32'hDEAD_BEEF, eerr:1'b1};
        tbl[8] = '{psel:8'h40, wr:1'b0, addr:32'h0000_0640, wdata:32'h0,         rdata:32'h0BAD_CAFE, waits:1,   lat:4,  edata:32'h0BAD_CAFE, eerr:1'b0};

        #3 chk_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 9; i++) run_xfer(tbl[i], 1'b0);

        // Clear landing on an error response: sticky cleared, count restarts at 1.
        run_xfer(tbl[3], 1'b1);

        // Master abort during ACCESS: strobes drop next cycle, no response, no error booked.
        wait_cfg[4] = 10; slave_data[4] = 32'h4444_4444;
        bus.m_psel = 8'h10; bus.m_penable = 1'b0; bus.m_pwrite = 1'b0; bus.m_paddr = 32'h400;
        @(posedge clk); #1 bus.m_penable = 1'b1;
        @(posedge clk); #1 bus.m_psel = 8'h00; bus.m_penable = 1'b0;
        @(posedge clk); #1 chk("abort_strobes", {bus.s_psel, bus.s_penable, bus.m_pready}, '0);
        @(posedge clk); #1 chk("abort_no_resp", {bus.m_pready, err_count, err_sticky}, {1'b0, 8'(exp_cnt), exp_sticky});
        run_xfer(tbl[0], 1'b0);

        // Reset pulsed mid-ACCESS: everything clears at once and no response follows.
        wait_cfg[3] = 10; slave_data[3] = 32'h3030_3030;
        bus.m_psel = 8'h08; bus.m_penable = 1'b0; bus.m_pwrite = 1'b0; bus.m_paddr = 32'h300;
        @(posedge clk); #1 bus.m_penable = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_all_zero("reset_mid_access");
        bus.m_psel = 8'h00; bus.m_penable = 1'b0;
        exp_cnt = 0; exp_sticky = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 chk("post_reset_no_pready", bus.m_pready, 1'b0);
        end
        run_xfer(tbl[8], 1'b0);

        for (int r = 0; r < 40; r++) begin
            int sel, mode;
            sel = $urandom_range(7, 0);
            mode = $urandom_range(9, 0);
            v.psel = 8'h01 << sel;
            if (mode == 0) v.psel = v.psel | (8'h01 << ((sel + 1 + $urandom_range(6, 0)) % 8));
            v.wr = 1'($urandom_range(1, 0));
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
            v.waits = (mode == 1) ? $urandom_range(40, 16) : $urandom_range(15, 0);
            model(v);
            run_xfer(v, mode == 2);
        end

        // 260 back-to-back timeouts: count saturates at 255.
        v = '{psel:8'h20, wr:1'b0, addr:32'h0000_0500, wdata:32'h0, rdata:32'h0, waits:100,
              lat:0, edata:32'h0, eerr:1'b0};
        model(v);
        for (int r = 0; r < 260; r++) run_xfer(v, 1'b0);
        chk("err_count_saturated", err_count, 8'd255);

        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        exp_cnt = 0; exp_sticky = 1'b0;
        chk("err_clr", {err_count, err_sticky}, {8'd0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
